// File: rtl/xspi_rx_frame_checker_if.sv
// Bus bundle for the xSPI receive frame checker: byte input, CRC engine
// hookup, verified payload output and response/status signals.
interface xspi_rx_frame_checker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       abort;
    logic [7:0] crc_data;
    logic       crc_enable;
    logic       crc_clear;
    logic [7:0] crc_value;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       ack;
    logic       nak;
    logic [3:0] retry_cnt;
    logic       retry_exhausted;

    // The checker sits on the slave side of the link.
    modport slave (
        input  rx_data, rx_valid, abort, crc_value, out_ready,
        output rx_ready, crc_data, crc_enable, crc_clear,
        output out_data, out_valid, out_last, ack, nak, retry_cnt, retry_exhausted
    );

    modport master (
        output rx_data, rx_valid, abort, crc_value, out_ready,
        input  rx_ready, crc_data, crc_enable, crc_clear,
        input  out_data, out_valid, out_last, ack, nak, retry_cnt, retry_exhausted
    );
endinterface

// File: rtl/xspi_rx_frame_checker.sv
// Receive frame checker: parses {len, payload, crc} frames, drives the external
// CRC-8 engine, holds the payload until verified, then drains with ACK or drops with NAK.
module xspi_rx_frame_checker #(
    parameter int MAX_LEN   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    xspi_rx_frame_checker_if.slave  bus
);

    localparam int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [3:0] MAX_RETRY_B = 4'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, DISCARD, DRAIN, RESP} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  idx_reg, idx_next;
    logic        good_reg, good_next;
    logic        oversize_reg, oversize_next;
    logic        aborted_reg, aborted_next;
    logic [3:0]  retry_cnt_reg, retry_cnt_next;
    logic        retry_exh_reg, retry_exh_next;
    logic [3:0]  retry_inc;

    logic [7:0]  buf_mem [MAX_LEN];
    logic        buf_we, buf_re;
    logic [AW-1:0] buf_waddr, buf_raddr;
    logic [7:0]  out_data_reg;

    logic        rx_ready_c, rx_accept, out_fire, last_beat;
    logic        crc_enable_c, crc_clear_c, out_valid_c, out_last_c, ack_c, nak_c;

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        good_next      = good_reg;
        oversize_next  = oversize_reg;
        aborted_next   = aborted_reg;
        retry_cnt_next = retry_cnt_reg;
        retry_exh_next = retry_exh_reg;
        retry_inc      = (retry_cnt_reg == 4'hF) ? 4'hF : retry_cnt_reg + 4'd1;
        buf_we         = 1'b0;
        buf_re         = 1'b0;
        buf_waddr      = AW'(idx_reg);
        buf_raddr      = '0;
        crc_enable_c   = 1'b0;
        crc_clear_c    = 1'b0;
        out_last_c     = 1'b0;
        ack_c          = 1'b0;
        nak_c          = 1'b0;

        rx_ready_c  = ((state_reg == IDLE) || (state_reg == PAYLOAD) ||
                       (state_reg == CRC)  || (state_reg == DISCARD)) && !bus.abort;
        rx_accept   = bus.rx_valid && rx_ready_c;
        out_valid_c = (state_reg == DRAIN);
        out_fire    = out_valid_c && bus.out_ready;
        last_beat   = (idx_reg == len_reg - 8'd1);

        case (state_reg)
            IDLE: begin
                if (rx_accept) begin
                    crc_enable_c = 1'b1;
                    len_next     = bus.rx_data;
                    idx_next     = 8'd0;
                    if (bus.rx_data > MAX_LEN_B) begin
                        oversize_next = 1'b1;
                        state_next    = DISCARD;
                    end else if (bus.rx_data == 8'd0) begin
                        state_next = CRC;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_accept) begin
                    crc_enable_c = 1'b1;
                    buf_we       = 1'b1;
                    idx_next     = idx_reg + 8'd1;
                    if (last_beat) state_next = CRC;
                end
            end
            CRC: begin
                // crc_value already reflects the last enabled byte (engine updates on negedge).
                if (rx_accept) begin
                    good_next = (bus.rx_data == bus.crc_value);
                    idx_next  = 8'd0;
                    if ((bus.rx_data == bus.crc_value) && (len_reg != 8'd0)) begin
                        buf_re     = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            DISCARD: begin
                // Length byte already taken; drop L payload bytes plus the CRC byte.
                if (rx_accept) begin
                    idx_next = idx_reg + 8'd1;
                    if (idx_reg == len_reg) state_next = RESP;
                end
            end
            DRAIN: begin
                out_last_c = last_beat;
                if (out_fire) begin
                    if (last_beat) begin
                        state_next = RESP;
                    end else begin
                        idx_next  = idx_reg + 8'd1;
                        buf_re    = 1'b1;
                        buf_raddr = AW'(idx_reg + 8'd1);
                    end
                end
            end
            RESP: begin
                crc_clear_c   = 1'b1;
                ack_c         = !aborted_reg && !oversize_reg && good_reg;
                nak_c         = !aborted_reg && (oversize_reg || !good_reg);
                aborted_next  = 1'b0;
                oversize_next = 1'b0;
                state_next    = IDLE;
                if (ack_c) begin
                    retry_cnt_next = 4'd0;
                    retry_exh_next = 1'b0;
                end else if (nak_c) begin
                    retry_cnt_next = retry_inc;
                    retry_exh_next = retry_exh_reg || (retry_inc >= MAX_RETRY_B);
                end
            end
            default: state_next = IDLE;
        endcase

        if (bus.abort && (state_reg != RESP)) begin
            aborted_next = 1'b1;
            state_next   = RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= 8'd0;
            idx_reg       <= 8'd0;
            good_reg      <= 1'b0;
            oversize_reg  <= 1'b0;
            aborted_reg   <= 1'b0;
            retry_cnt_reg <= 4'd0;
            retry_exh_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            idx_reg       <= idx_next;
            good_reg      <= good_next;
            oversize_reg  <= oversize_next;
            aborted_reg   <= aborted_next;
            retry_cnt_reg <= retry_cnt_next;
            retry_exh_reg <= retry_exh_next;
        end
    end

    // Payload buffer with registered read; out_data only moves on a read, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[buf_waddr] <= bus.rx_data;
        if (buf_re) out_data_reg <= buf_mem[buf_raddr];
    end

    assign bus.rx_ready        = rx_ready_c;
    assign bus.crc_data        = bus.rx_data;
    assign bus.crc_enable      = crc_enable_c;
    assign bus.crc_clear       = crc_clear_c;
    assign bus.out_data        = out_data_reg;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_last        = out_last_c;
    assign bus.ack             = ack_c;
    assign bus.nak             = nak_c;
    assign bus.retry_cnt       = retry_cnt_reg;
    assign bus.retry_exhausted = retry_exh_reg;

endmodule

// File: tb/tb_xspi_rx_frame_checker.sv
// Scoreboard bench for xspi_rx_frame_checker: directed frames then random traffic,
// with a CRC-8 engine model on the negedge and a frame-level reference model.
module tb_xspi_rx_frame_checker;

    localparam int MAX_LEN   = 16;
    localparam int MAX_RETRY = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xspi_rx_frame_checker_if bus();

    xspi_rx_frame_checker #(.MAX_LEN(MAX_LEN), .MAX_RETRY(MAX_RETRY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Neighbouring CRC engine: updates on the falling edge.
    logic [7:0] crc_eng;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)              crc_eng <= 8'h00;
        else if (bus.crc_clear)  crc_eng <= 8'h00;
        else if (bus.crc_enable) crc_eng <= crc8_byte(crc_eng, bus.crc_data);
    end
    assign bus.crc_value = crc_eng;

    typedef struct { logic [7:0] data; logic last; } beat_t;
    typedef struct { int kind; logic [3:0] retry; logic exh; } resp_t;  // kind: 0 none, 1 ack, 2 nak

    beat_t out_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    model_retry = 0;
    bit    model_exh = 1'b0;
    bit    mon_en = 1'b0;
    bit    force_stall = 1'b1;
    bit    ready_rand = 1'b0;
    logic [7:0] dpl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s t=%0t", what, $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "run stopped");
    endtask

    task automatic push_resp(input int kind);
        resp_t r;
        if (kind == 1) begin
            model_retry = 0;
            model_exh   = 1'b0;
        end else if (kind == 2) begin
            model_retry = (model_retry >= 15) ? 15 : model_retry + 1;
            if (model_retry >= MAX_RETRY) model_exh = 1'b1;
        end
        r.kind  = kind;
        r.retry = 4'(model_retry);
        r.exh   = model_exh;
        resp_q.push_back(r);
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] d);
        int n;
        bit rdy;
        n = 0;
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = bus.rx_ready;
            @(posedge clk);
            #1;
            n++;
            if (!rdy && n > 1000) timeout("rx_ready");
        end while (!rdy);
    endtask

    task automatic send_data_frame(input logic [7:0] pl[$], input logic [7:0] flip);
        logic [7:0] c;
        beat_t b;
        int len;
        len = pl.size();
        c = crc8_byte(8'h00, 8'(len));
        foreach (pl[i]) c = crc8_byte(c, pl[i]);
        c = c ^ flip;
        if (flip == 8'h00) begin
            foreach (pl[i]) begin
                b.data = pl[i];
                b.last = (i == len - 1);
                out_q.push_back(b);
            end
            push_resp(1);
        end else begin
            push_resp(2);
        end
        send_byte(8'(len));
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(c);
        bus.rx_valid = 1'b0;
    endtask

    task automatic oversize_frame(input int len);
        push_resp(2);
        send_byte(8'(len));
        repeat (len + 1) send_byte(8'($urandom));
        bus.rx_valid = 1'b0;
    endtask

    task automatic abort_frame(input int len, input int k);
        push_resp(0);
        send_byte(8'(len));
        repeat (k) send_byte(8'($urandom));
        bus.abort    = 1'b1;
        bus.rx_data  = 8'($urandom);
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check("abort_rx_ready", bus.rx_ready, 0);
        check("abort_crc_enable", bus.crc_enable, 0);
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.rx_valid = 1'b0;
        check("abort_resp_clear", bus.crc_clear, 1);
        check("abort_no_ack_nak", {bus.ack, bus.nak}, 0);
    endtask

    task automatic rand_payload(input int len);
        dpl = {};
        for (int i = 0; i < len; i++) dpl.push_back(8'($urandom));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (out_q.size() != 0 || resp_q.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 3000) timeout("scoreboard drain");
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = force_stall ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a response cycle.
    initial begin
        bit    pend;
        resp_t pr;
        beat_t b;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("retry_cnt", bus.retry_cnt, pr.retry);
                check("retry_exhausted", bus.retry_exhausted, pr.exh);
                pend = 1'b0;
            end
            if (bus.rx_valid) check("crc_data", bus.crc_data, bus.rx_data);
            if (bus.out_valid && out_q.size() == 0) begin
                check("unexpected_out_valid", bus.out_valid, 0);
            end else if (bus.out_valid && bus.out_ready) begin
                b = out_q.pop_front();
                check("out_data", bus.out_data, b.data);
                check("out_last", bus.out_last, b.last);
            end
            if (bus.crc_clear) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp_cycle", bus.crc_clear, 0);
                end else begin
                    pr = resp_q.pop_front();
                    check("ack", bus.ack, pr.kind == 1);
                    check("nak", bus.nak, pr.kind == 2);
                    pend = 1'b1;
                end
            end else begin
                check("ack_nak_outside_resp", {bus.ack, bus.nak}, 0);
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.abort    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ack_nak", {bus.ack, bus.nak}, 0);
        check("rst_crc_clear", bus.crc_clear, 0);
        check("rst_crc_enable", bus.crc_enable, 0);
        check("rst_retry_cnt", bus.retry_cnt, 0);
        check("rst_retry_exhausted", bus.retry_exhausted, 0);
        check("rst_rx_ready", bus.rx_ready, 1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        force_stall = 1'b0;
        @(posedge clk);
        #1;

        // Empty frame: ack one cycle after the CRC byte.
        dpl = {};
        send_data_frame(dpl, 8'h00);
        check("l0_ack_latency", bus.ack, 1);
        check("l0_crc_clear", bus.crc_clear, 1);
        check("l0_no_out_valid", bus.out_valid, 0);
        wait_idle();

        dpl = {8'h00};
        send_data_frame(dpl, 8'h00);
        check("l1_first_out_latency", bus.out_valid, 1);
        wait_idle();

        // Stalled drain: data held, no ack until the handshake.
        force_stall = 1'b1;
        dpl = {8'h5A};
        send_data_frame(dpl, 8'h00);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_last", bus.out_last, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_hold_data", bus.out_data, 8'h5A);
            check("stall_no_ack", bus.ack, 0);
        end
        force_stall = 1'b0;
        wait_idle();

        // Three bad CRCs, then a good frame clears the retry state.
        dpl = {8'h00};
        for (int i = 1; i <= 3; i++) begin
            send_data_frame(dpl, 8'h01);
            check("bad_nak_latency", bus.nak, 1);
            wait_idle();
            check("retry_step", bus.retry_cnt, i);
        end
        check("retry_exhausted_set", bus.retry_exhausted, 1);
        send_data_frame(dpl, 8'h00);
        wait_idle();
        check("retry_cleared", bus.retry_cnt, 0);
        check("exhausted_cleared", bus.retry_exhausted, 0);

        oversize_frame(32);
        check("oversize_nak_latency", bus.nak, 1);
        wait_idle();
        dpl = {};
        send_data_frame(dpl, 8'h00);
        wait_idle();

        abort_frame(4, 2);
        wait_idle();
        rand_payload(3);
        send_data_frame(dpl, 8'h00);
        wait_idle();

        // Asynchronous reset in the middle of a drain.
        force_stall = 1'b1;
        rand_payload(4);
        send_data_frame(dpl, 8'h00);
        check("pre_reset_out_valid", bus.out_valid, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", bus.out_valid, 0);
        check("mid_reset_out_last", bus.out_last, 0);
        check("mid_reset_ack_nak", {bus.ack, bus.nak}, 0);
        check("mid_reset_crc_clear", bus.crc_clear, 0);
        check("mid_reset_retry", bus.retry_cnt, 0);
        check("mid_reset_rx_ready", bus.rx_ready, 1);
        out_q.delete();
        resp_q.delete();
        model_retry = 0;
        model_exh   = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        force_stall = 1'b0;
        mon_en = 1'b1;
        rand_payload(5);
        send_data_frame(dpl, 8'h00);
        wait_idle();

        ready_rand = 1'b1;
        for (int f = 0; f < 150; f++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                rand_payload($urandom_range(0, MAX_LEN));
                send_data_frame(dpl, 8'h00);
            end else if (kind <= 7) begin
                rand_payload($urandom_range(0, MAX_LEN));
                send_data_frame(dpl, 8'(1 << $urandom_range(0, 7)));
            end else if (kind == 8) begin
                oversize_frame($urandom_range(MAX_LEN + 1, MAX_LEN + 20));
            end else begin
                len = $urandom_range(2, MAX_LEN);
                abort_frame(len, $urandom_range(1, len - 1));
            end
            gap();
        end
        wait_idle();
        check("final_out_q_empty", out_q.size(), 0);
        check("final_resp_q_empty", resp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
